regfile_sb: RTL

Parametrised integer register file with per-register pending-write scoreboard and an N-deep forwarding network, for the in-order RISC-V pipeline. It replaces the fixed 2-read, 3-source register file. It adds configurable read-port and bypass counts, synchronous clearing of the array, and issue-time tracking of in-flight writers. A read therefore reports success only when the value it returns is architecturally current. It sits between ID (issue/read) and EX/MEM/WB (bypass/write-back).

---
 rtl/regfile_sb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-writer scoreboard
// and an N-deep forwarding network for the in-order pipeline.
module regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int NRP   = 2,
   parameter int NFWD  = 2,
   parameter int CW    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [XLEN-1:0]      wdata,
   input  logic [NFWD-1:0]      fwd_we,
   input  logic [NFWD-1:0]      fwd_rdy,
   input  logic [NFWD*AW-1:0]   fwd_addr,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   output logic                 iss_ready,
   input  logic                 flush,
   input  logic [NRP-1:0]       re,
   input  logic [NRP*AW-1:0]    raddr,
   output logic [NRP*XLEN-1:0]  rdata,
   output logic [NRP-1:0]       rsuc,
   output logic                 wb_orphan
);

   localparam int MW   = $clog2(NFWD + 2);
   localparam int CMPW = (MW > CW) ? MW : CW;
   localparam logic [CW-1:0] CMAX = '1;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [CW-1:0]   cnt_q  [NREGS];
   logic [CW-1:0]   cnt_d  [NREGS];
   logic            orphan_q;
   logic            orphan_set;
   logic            wb_live;
   logic            dec_rd;

   assign wb_live    = we && (waddr != '0);
   assign orphan_set = wb_live && (cnt_q[waddr] == '0) && !flush;

   // A write-back retiring on iss_rd frees a slot in the same cycle
   assign dec_rd    = we && (waddr == iss_rd) && (iss_rd != '0)
                   && (cnt_q[iss_rd] != '0);
   assign iss_ready = !rst && ((iss_rd == '0)
                   || (cnt_q[iss_rd] != CMAX) || dec_rd);

   assign wb_orphan = orphan_q && !rst;

   always_comb begin
      logic inc_v;
      logic dec_v;
      for (int r = 0; r < NREGS; r++) begin
         inc_v = iss_valid && iss_ready
              && (iss_rd == AW'(r)) && (r != 0);
         dec_v = we && (waddr == AW'(r)) && (r != 0)
              && (cnt_q[r] != '0);
         cnt_d[r] = cnt_q[r];
         if (flush)
            cnt_d[r] = '0;
         else if (inc_v && !dec_v)
            cnt_d[r] = cnt_q[r] + CW'(1);
         else if (dec_v && !inc_v)
            cnt_d[r] = cnt_q[r] - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         orphan_q <= 1'b0;
      end else begin
         if (wb_live)
            regs_q[waddr] <= wdata;
         for (int r = 0; r < NREGS; r++)
            cnt_q[r] <= cnt_d[r];
         if (orphan_set)
            orphan_q <= 1'b1;
      end
   end

   // Youngest matching source wins; the match count must equal the
   // number of in-flight writers for the value to be current.
   always_comb begin
      logic [AW-1:0]   a;
      logic [MW-1:0]   m;
      logic [XLEN-1:0] d;
      logic            hit;
      logic            ok;
      rdata = '0;
      rsuc  = '0;
      for (int p = 0; p < NRP; p++) begin
         a   = raddr[p*AW +: AW];
         m   = '0;
         d   = '0;
         hit = 1'b0;
         ok  = 1'b0;
         if (!rst && re[p]) begin
            if (a == '0) begin
               rsuc[p] = 1'b1;
            end else begin
               if (we && (waddr == a)) begin
                  m   = m + MW'(1);
                  hit = 1'b1;
                  d   = wdata;
                  ok  = 1'b1;
               end
               for (int i = NFWD - 1; i >= 0; i--) begin
                  if (fwd_we[i] && (fwd_addr[i*AW +: AW] == a)) begin
                     m   = m + MW'(1);
                     hit = 1'b1;
                     d   = fwd_data[i*XLEN +: XLEN];
                     ok  = fwd_rdy[i];
                  end
               end
               if (!hit) begin
                  rdata[p*XLEN +: XLEN] = regs_q[a];
                  rsuc[p] = (cnt_q[a] == '0);
               end else begin
                  rdata[p*XLEN +: XLEN] = d;
                  rsuc[p] = (CMPW'(m) == CMPW'(cnt_q[a])) && ok;
               end
            end
         end
      end
   end

endmodule
